// File: rtl/cntdiv_pkg.sv
// Shared types and helpers for the dual-rate clock divider and its decoder.
package cntdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_LONG  = 1'b0,
        MODE_SHORT = 1'b1
    } mode_t;

    // Width of the operands handed to in_window; counter widths must stay below it
    localparam int VAL_W = 32;

    // True when |val - target| <= tol, evaluated one bit wider and signed so nothing wraps
    function automatic logic in_window(input logic [VAL_W-1:0] val,
                                       input logic [VAL_W-1:0] target,
                                       input logic [VAL_W-1:0] tol);
        logic signed [VAL_W:0] diff;
        diff = $signed({1'b0, val}) - $signed({1'b0, target});
        if (diff < 0) begin
            diff = -diff;
        end
        return (diff <= $signed({1'b0, tol}));
    endfunction

endpackage

// File: rtl/cntdiv_decoder_if.sv
// Signal bundle between a divided-waveform source (master) and the decoder (slave).
interface cntdiv_decoder_if #(
    parameter int TOPVALUE = 50_000_000
);
    localparam int W = $clog2(2 * TOPVALUE + 1);

    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         mode;
    logic         err;
    logic         timeout;
    logic         duty_err;

    modport master (
        output sig_in,
        input  period, high_time, valid, mode, err, timeout, duty_err
    );

    modport slave (
        input  sig_in,
        output period, high_time, valid, mode, err, timeout, duty_err
    );

endinterface

// File: rtl/cntdiv_decoder_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus one delay flop for rise/fall pulses.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES:0] chain;
    logic                 last_reg;

    assign chain[0] = din;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic q_reg;
            // One synchronizer stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q_reg <= 1'b0;
                else     q_reg <= chain[gi];
            end
            assign chain[gi+1] = q_reg;
        end
    endgenerate

    assign level = chain[SYNC_STAGES];

    // Previous synchronized level, used to form the edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_reg <= 1'b0;
        else     last_reg <= level;
    end

    assign rise = level & ~last_reg;
    assign fall = ~level & last_reg;

endmodule

// File: rtl/cntdiv_decoder.sv
// Decoder for the dual-rate divider output: measures period/high time, classifies short/long.
// Optional build macro: DUTY_CHECK_EN enables the 50% duty comparator (duty_err).
module cntdiv_decoder
    import cntdiv_pkg::*;
#(
    parameter int TOPVALUE    = 50_000_000,
    parameter int TOL         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    cntdiv_decoder_if.slave     bus
);

    localparam int W = $clog2(2 * TOPVALUE + 1);

    localparam logic [W-1:0]     CNT_MAX  = W'(2 * TOPVALUE);
    localparam logic [VAL_W-1:0] SHORT_T  = VAL_W'(TOPVALUE / 2);
    localparam logic [VAL_W-1:0] LONG_T   = VAL_W'(TOPVALUE);
    localparam logic [VAL_W-1:0] TOL_V    = VAL_W'(TOL);

    logic         rise;
    logic         fall;
    logic         level;

    state_t       state_reg;
    state_t       state_next;

    logic         start_meas;
    logic         measure_done;
    logic         timeout_hit;

    logic [W-1:0] cnt_reg;
    logic [W-1:0] hcnt_reg;
    logic [W-1:0] period_reg;
    logic [W-1:0] high_time_reg;
    logic         valid_reg;
    mode_t        mode_reg;
    logic         err_reg;
    logic         timeout_reg;

    logic         short_hit;
    logic         long_hit;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.sig_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // FSM next-state: a rise in LOW beats the timeout threshold
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (rise) state_next = HIGH;
            HIGH: begin
                if (cnt_reg == CNT_MAX) state_next = IDLE;
                else if (fall)          state_next = LOW;
            end
            LOW: begin
                if (rise)                    state_next = HIGH;
                else if (cnt_reg == CNT_MAX) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: datapath control strobes
    always_comb begin
        start_meas   = 1'b0;
        measure_done = 1'b0;
        timeout_hit  = 1'b0;
        case (state_reg)
            IDLE: start_meas = rise;
            HIGH: timeout_hit = (cnt_reg == CNT_MAX);
            LOW: begin
                measure_done = rise;
                timeout_hit  = ~rise && (cnt_reg == CNT_MAX);
            end
            default: ;
        endcase
    end

    assign short_hit = in_window(VAL_W'(cnt_reg), SHORT_T, TOL_V);
    assign long_hit  = in_window(VAL_W'(cnt_reg), LONG_T,  TOL_V);

    // Period and high-time counters; fall cycle already belongs to the low phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            hcnt_reg <= '0;
        end else if (start_meas || measure_done) begin
            cnt_reg  <= W'(1);
            hcnt_reg <= W'(1);
        end else if (timeout_hit) begin
            cnt_reg  <= '0;
            hcnt_reg <= '0;
        end else if (state_reg != IDLE) begin
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + W'(1);
            if (state_reg == HIGH && !fall && hcnt_reg != CNT_MAX)
                hcnt_reg <= hcnt_reg + W'(1);
        end
    end

    // Result registers and classification, updated once per completed period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_reg    <= '0;
            high_time_reg <= '0;
            valid_reg     <= 1'b0;
            mode_reg      <= MODE_LONG;
            err_reg       <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            valid_reg   <= measure_done;
            timeout_reg <= timeout_hit;
            if (measure_done) begin
                period_reg    <= cnt_reg;
                high_time_reg <= hcnt_reg;
                err_reg       <= ~(short_hit | long_hit);
                if (short_hit)     mode_reg <= MODE_SHORT;
                else if (long_hit) mode_reg <= MODE_LONG;
            end
        end
    end

`ifdef DUTY_CHECK_EN
    localparam logic [VAL_W-1:0] TOL2_V = VAL_W'(2 * TOL);

    logic duty_reg;
    logic duty_ok;

    assign duty_ok = in_window(VAL_W'({hcnt_reg, 1'b0}), VAL_W'(cnt_reg), TOL2_V);

    // Duty flag: twice the high time must sit within 2*TOL of the period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               duty_reg <= 1'b0;
        else if (measure_done) duty_reg <= ~duty_ok;
    end

    assign bus.duty_err = duty_reg;
`else
    assign bus.duty_err = 1'b0;
`endif

    assign bus.period    = period_reg;
    assign bus.high_time = high_time_reg;
    assign bus.valid     = valid_reg;
    assign bus.mode      = mode_reg;
    assign bus.err       = err_reg;
    assign bus.timeout   = timeout_reg;

    // level is only consumed through the edge pulses here
    logic unused_level;
    assign unused_level = level;

endmodule

// File: tb/tb_cntdiv_decoder.sv
// Directed bench for cntdiv_decoder at TOPVALUE=40, TOL=2.
module tb_cntdiv_decoder;

    localparam int TOPVALUE = 40;
    localparam int TOL      = 2;
    localparam int NEXP     = 12;

`ifdef DUTY_CHECK_EN
    localparam bit DUTY_ON = 1'b1;
`else
    localparam bit DUTY_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int tmo_count = 0;

    typedef struct {
        int unsigned period;
        int unsigned high_time;
        bit          mode;
        bit          err;
        bit          duty;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_tab[NEXP];

    always #5 clk = ~clk;

    cntdiv_decoder_if #(.TOPVALUE(TOPVALUE)) bus ();

    cntdiv_decoder #(
        .TOPVALUE    (TOPVALUE),
        .TOL         (TOL),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Record every valid pulse and count timeout pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                rec_t r;
                r.period    = int'(bus.period);
                r.high_time = int'(bus.high_time);
                r.mode      = bus.mode;
                r.err       = bus.err;
                r.duty      = bus.duty_err;
                got_q.push_back(r);
                $display("valid: period=%0d high=%0d mode=%0d err=%0d duty=%0d",
                         r.period, r.high_time, r.mode, r.err, r.duty);
            end
            if (bus.timeout) tmo_count++;
        end
    end

    task automatic hold(input logic val, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.sig_in = val;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int h, input int l);
        hold(1'b1, h);
        hold(1'b0, l);
    endtask

    task automatic set_exp(input int idx, input int p, input int h, input bit m, input bit e, input bit d);
        exp_tab[idx].period    = p;
        exp_tab[idx].high_time = h;
        exp_tab[idx].mode      = m;
        exp_tab[idx].err       = e;
        exp_tab[idx].duty      = d & DUTY_ON;
    endtask

    initial begin
        set_exp(0,  20, 10, 1'b1, 1'b0, 1'b0);
        set_exp(1,  20, 10, 1'b1, 1'b0, 1'b0);
        set_exp(2,  20, 10, 1'b1, 1'b0, 1'b0);
        set_exp(3,  40, 20, 1'b0, 1'b0, 1'b0);
        set_exp(4,  40, 20, 1'b0, 1'b0, 1'b0);
        set_exp(5,  30, 15, 1'b0, 1'b1, 1'b0);
        set_exp(6,  20, 10, 1'b1, 1'b0, 1'b0);
        set_exp(7,  20, 10, 1'b1, 1'b0, 1'b0);
        set_exp(8,  40, 30, 1'b0, 1'b0, 1'b1);
        set_exp(9,  40, 20, 1'b0, 1'b0, 1'b0);
        set_exp(10, 40, 20, 1'b0, 1'b0, 1'b0);
        set_exp(11, 40, 20, 1'b0, 1'b0, 1'b0);

        bus.sig_in = 1'b0;
        rst = 1'b1;
        hold(1'b0, 3);
        @(negedge clk);
        check("rst_period",    bus.period,    0);
        check("rst_high_time", bus.high_time, 0);
        check("rst_valid",     bus.valid,     0);
        check("rst_mode",      bus.mode,      0);
        check("rst_err",       bus.err,       0);
        check("rst_timeout",   bus.timeout,   0);
        check("rst_duty",      bus.duty_err,  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b0, 5);

        // short, then long, then an out-of-window period, then short again
        for (int i = 0; i < 3; i++) send(10, 10);
        for (int i = 0; i < 2; i++) send(20, 20);
        send(15, 15);
        send(10, 10);
        send(10, 10);

        // held high long enough to time out
        hold(1'b1, 100);
        hold(1'b0, 20);
        check("timeout_count", tmo_count, 1);
        check("valid_before_to", got_q.size(), 8);
        check("hold_period", bus.period, 20);
        check("hold_high",   bus.high_time, 10);
        check("hold_mode",   bus.mode, 1);

        // first rise after timeout is a fresh start, no valid
        send(30, 10);
        check("no_valid_after_to", got_q.size(), 8);
        send(20, 20);
        send(20, 20);
        hold(1'b1, 20);
        hold(1'b0, 8);

        // reset mid-LOW clears outputs without waiting for a clock
        rst = 1'b1;
        #1;
        check("mid_rst_period", bus.period, 0);
        check("mid_rst_high",   bus.high_time, 0);
        check("mid_rst_mode",   bus.mode, 0);
        check("mid_rst_err",    bus.err, 0);
        hold(1'b0, 3);
        rst = 1'b0;
        hold(1'b0, 5);
        send(20, 20);
        check("no_valid_after_rst", got_q.size(), 11);
        hold(1'b1, 20);
        hold(1'b0, 10);

        check("valid_total", got_q.size(), NEXP);
        for (int i = 0; i < NEXP && i < got_q.size(); i++) begin
            check($sformatf("v%0d_period", i), got_q[i].period,    exp_tab[i].period);
            check($sformatf("v%0d_high", i),   got_q[i].high_time, exp_tab[i].high_time);
            check($sformatf("v%0d_mode", i),   got_q[i].mode,      exp_tab[i].mode);
            check($sformatf("v%0d_err", i),    got_q[i].err,       exp_tab[i].err);
            check($sformatf("v%0d_duty", i),   got_q[i].duty,      exp_tab[i].duty);
        end
        check("timeout_total", tmo_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
